// File: rtl/mips_cpu_hilo_muldiv.sv
// Multi-cycle MIPS multiply/divide unit owning the architectural HI/LO registers.
// Optional single-cycle multiplier: define MIPS_CPU_MULDIV_FAST_MUL_EN.
module mips_cpu_hilo_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              sign_a, sign_b, is_div;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   rem, quot;

  logic              signed_op;
  logic [XLEN-1:0]   a_mag_in, b_mag_in;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift, div_diff;
  logic              div_fits;
  logic [2*XLEN-1:0] mul_mag, mul_res;
  logic [XLEN-1:0]   q_res, r_res, dividend_raw;

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE: if (start && !op[2]) begin
        if (op[1]) state_nxt = DIV;
        else begin
`ifdef MIPS_CPU_MULDIV_FAST_MUL_EN
          state_nxt = FIN;
`else
          state_nxt = MUL;
`endif
        end
      end
      MUL:     if (cnt == '1) state_nxt = FIN;
      DIV:     if (cnt == '1) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Signed ops run unsigned on magnitudes; signs are reapplied in FIN.
  always_comb begin
    signed_op    = !op[0];
    a_mag_in     = (signed_op && rs_data[XLEN-1]) ? -rs_data : rs_data;
    b_mag_in     = (signed_op && rt_data[XLEN-1]) ? -rt_data : rt_data;
    mul_sum      = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, a_mag} : '0);
    div_shift    = {rem, quot[XLEN-1]};
    div_fits     = (div_shift >= {1'b0, b_mag});
    div_diff     = div_shift - {1'b0, b_mag};
`ifdef MIPS_CPU_MULDIV_FAST_MUL_EN
    mul_mag      = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`else
    mul_mag      = prod;
`endif
    mul_res      = (sign_a ^ sign_b) ? -mul_mag : mul_mag;
    q_res        = (sign_a ^ sign_b) ? -quot : quot;
    r_res        = sign_a ? -rem : rem;
    dividend_raw = sign_a ? -a_mag : a_mag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      cnt    <= '0;
      a_mag  <= '0;
      b_mag  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      is_div <= 1'b0;
      prod   <= '0;
      rem    <= '0;
      quot   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              a_mag  <= a_mag_in;
              b_mag  <= b_mag_in;
              sign_a <= signed_op & rs_data[XLEN-1];
              sign_b <= signed_op & rt_data[XLEN-1];
              is_div <= op[1];
              cnt    <= '0;
              prod   <= {{XLEN{1'b0}}, b_mag_in};
              rem    <= '0;
              quot   <= a_mag_in;
            end
            3'd4:    hi <= rs_data;
            3'd5:    lo <= rs_data;
            default: ;
          endcase
        end
        MUL: begin
          prod <= {mul_sum, prod[XLEN-1:1]};
          cnt  <= cnt + 1'b1;
        end
        DIV: begin
          rem  <= div_fits ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
          quot <= {quot[XLEN-2:0], div_fits};
          cnt  <= cnt + 1'b1;
        end
        FIN: begin
          done <= 1'b1;
          if (!is_div) {hi, lo} <= mul_res;
          else if (b_mag == '0) begin
            // Divide by zero reports the original dividend untouched.
            hi <= dividend_raw;
            lo <= '1;
          end else begin
            hi <= r_res;
            lo <= q_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_hilo_muldiv.sv
// Scoreboard bench for mips_cpu_hilo_muldiv: expected HI/LO queued at issue, checked on done.
module tb_mips_cpu_hilo_muldiv;

  logic        clk = 1'b0;
  logic        reset, start, busy, done;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data, hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] exp_q[$];

`ifdef MIPS_CPU_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  mips_cpu_hilo_muldiv #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int     ia, ib;
    case (o)
      3'd0: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
      end
      3'd1: return {32'b0, a} * {32'b0, b};
      3'd2: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        ia = a;
        ib = b;
        return {32'(ia % ib), 32'(ia / ib)};
      end
      3'd3: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: return 64'h0;
    endcase
  endfunction

  always @(negedge clk) begin : sb_check
    logic [63:0] e;
    if (!reset && done) begin
      if (exp_q.size() == 0) check("unexpected_done", 64'(done), 64'd0);
      else begin
        e = exp_q.pop_front();
        check("result", {hi, lo}, e);
        check("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit poke);
    logic [63:0] old;
    int          n, lat;
    bit          seen;
    lat = o[1] ? DIV_LAT : MUL_LAT;
    @(negedge clk);
    old     = {hi, lo};
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    exp_q.push_back(model(o, a, b));
    @(negedge clk);
    start   = 1'b0;
    rs_data = $urandom;
    rt_data = $urandom;
    n       = 1;
    seen    = 1'b0;
    check("busy_on", 64'(busy | done), 64'd1);
    while (n < 100 && !seen) begin
      if (done) seen = 1'b1;
      else begin
        if (n == 10) check("hold_hilo", {hi, lo}, old);
        if (poke && n == 5) begin start = 1'b1; op = 3'd4; rs_data = 32'h11111111; end
        if (poke && n == 6) begin start = 1'b0; check("mthi_while_busy", 64'(hi), 64'(old[63:32])); end
        if (poke && n == lat - 1) begin start = 1'b1; op = 3'd5; rs_data = 32'h55555555; end
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    check("latency", 64'(n), 64'(lat));
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] snap;
    reset = 1'b1; start = 1'b0; op = 3'd0; rs_data = '0; rt_data = '0;
    repeat (2) @(negedge clk);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    reset = 1'b0;

    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    issue(3'd0, 32'hFFFFFFFE, 32'h00000003, 1'b0);
    issue(3'd2, 32'hFFFFFFF9, 32'h00000002, 1'b0);
    issue(3'd3, 32'd100,      32'd7,        1'b0);
    issue(3'd3, 32'h12345678, 32'h0,        1'b0);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    issue(3'd2, 32'hFFFFFFFB, 32'h0,        1'b0);
    issue(3'd2, 32'h00000007, 32'hFFFFFFFE, 1'b0);
    for (int i = 0; i < 6; i++)
      issue(3'($urandom_range(0, 3)), $urandom, $urandom, 1'b0);

    // MTHI / MTLO back to back, then a no-op
    @(negedge clk);
    snap = {hi, lo};
    start = 1'b1; op = 3'd4; rs_data = 32'hDEADBEEF;
    @(negedge clk);
    check("mthi_hi", 64'(hi), 64'hDEADBEEF);
    check("mthi_lo", 64'(lo), 64'(snap[31:0]));
    check("mthi_busy", 64'(busy), 64'd0);
    op = 3'd5; rs_data = 32'hCAFEF00D;
    @(negedge clk);
    check("mtlo_hilo", {hi, lo}, 64'hDEADBEEF_CAFEF00D);
    check("mtlo_busy_done", 64'({busy, done}), 64'd0);
    op = 3'd6; rs_data = 32'h0; rt_data = 32'h0;
    @(negedge clk);
    start = 1'b0;
    check("noop_hilo", {hi, lo}, 64'hDEADBEEF_CAFEF00D);
    check("noop_busy", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of a divide
    start = 1'b1; op = 3'd2; rs_data = 32'd7; rt_data = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("async_rst_hilo", {hi, lo}, 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    issue(3'd1, 32'd3, 32'd5, 1'b0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_cpu_hilo_muldiv.md
Name: mips_cpu_hilo_muldiv

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits directly downstream of the register file: consumes rs/rt read data (read ports 1/2) on MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- Exposes HI/LO to the writeback mux for MFHI/MFLO, and busy to the control unit for stalling.

Parameters:
- XLEN, 32, operand width; HI/LO each XLEN; only 32 is verified.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on a clk edge only when busy=0.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=no-op.
- rs_data  input  XLEN  operand A / dividend / MTHI-MTLO source (register file read_data_1).
- rt_data  input  XLEN  operand B / divisor (register file read_data_2).
- busy  output  1  high while a multiply or divide is in flight.
- done  output  1  one-cycle pulse when a multiply/divide result lands in HI/LO.
- hi  output  XLEN  architectural HI.
- lo  output  XLEN  architectural LO.

Behaviour:
- Reset (async, any time, including mid-operation):
  - hi=0, lo=0, busy=0, done=0.
  - FSM goes to IDLE; any in-flight operation is discarded.
- FSM states: IDLE, MUL, DIV, FIN.
- Operand capture:
  - In IDLE with start=1 and op in 0..3, rs_data/rt_data are latched into internal registers at that edge (edge k).
  - Operands may change afterwards without effect.
- Signed ops (MULT, DIV):
  - Latch magnitudes plus sign bits.
  - Compute unsigned.
  - Apply sign correction in FIN.
- MUL: shift-add, one multiplier bit per cycle, 32 iterations on edges k+1..k+32, then FIN.
- DIV: restoring division, one quotient bit per cycle, 32 iterations on edges k+1..k+32, then FIN.
- FIN (edge k+33): result written to HI/LO, FSM returns to IDLE, done=1 for exactly that cycle.
  - Multiply: {hi,lo} = 64-bit product.
  - Divide: lo = quotient, hi = remainder.
- Timing: busy=1 after edge k through edge k+33 (33 cycles), then 0 in the same cycle done=1.
- hi/lo hold their previous values throughout MUL/DIV; partial results live in separate internal registers.
- Signed correction:
  - Product negated if signs differ.
  - Quotient negated if signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero (DIV or DIVU, rt=0): full 33-cycle latency, then lo=32'hFFFFFFFF, hi=rs_data as latched (raw, no sign fix).
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO:
  - With busy=0 and start=1: hi (resp. lo) = rs_data at the next edge.
  - busy stays 0 and done stays 0; the other register is unchanged.
- Requests while busy: start is ignored (no queueing); control must stall MFHI/MFLO/MT*/mul/div while busy=1.
- Ops 6/7: no state change.
- Same-cycle events: at the FIN edge busy=1, so a start on that edge is ignored; a new op is accepted on the following edge.

Optional Feature:
- Macro: MIPS_CPU_MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU use a single combinational 64-bit multiply registered at edge k+1.
  - busy=1 for exactly one cycle (after edge k); hi/lo updated and done=1 after edge k+1.
  - DIV/DIVU are unchanged.
- Undefined: the 33-cycle iterative multiplier described above is used.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> busy 33 cycles; then hi=0xFFFFFFFE, lo=0x00000001, done pulses once.
- MULT rs=0xFFFFFFFE (-2), rt=0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; hi/lo keep old values until done.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU rs=100, rt=7 -> lo=14, hi=2.
- DIVU rs=0x12345678, rt=0 -> after 33 cycles lo=0xFFFFFFFF, hi=0x12345678; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI rs=0xDEADBEEF then MTLO rs=0xCAFEF00D on consecutive cycles -> hi/lo updated one edge after each, busy never asserts. A start with op=MTHI while busy -> hi unchanged.
- Start DIV, assert reset at cycle 10 -> hi=lo=0, busy=0 immediately (asynchronous). The next MULTU 3*5 completes normally with lo=15, hi=0.
